date_set_ctrl: RTL and testbench



---
 rtl/date_set_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_date_set_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/date_set_ctrl.sv
// Day/month/year BCD date keeper with debounced key-driven field setting,
// calendar-correct daily advance and blinking selected-field request.

module date_set_ctrl #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  KEY,
  input  logic        day_tick,
  output logic [7:0]  day_bcd,
  output logic [7:0]  month_bcd,
  output logic [15:0] year_bcd,
  output logic [1:0]  mode,
  output logic [2:0]  blank
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_DAY   = 2'd1,
    SET_MONTH = 2'd2,
    SET_YEAR  = 2'd3
  } mode_e;

  mode_e         mode_q;
  mode_e         mode_d;
  logic [7:0]    day_q;
  logic [7:0]    day_d;
  logic [7:0]    mon_q;
  logic [7:0]    mon_d;
  logic [7:0]    yr_q;
  logic [7:0]    yr_d;
  logic [7:0]    mx_cur;
  logic [7:0]    mx_new;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    deb;
  logic [3:0]    press;
  logic [3:0]    act;
  logic [DW-1:0] dcnt [4];
  logic [BW-1:0] bcnt;
  logic          phase;

  function automatic logic is_leap(input logic [7:0] y);
    logic r;
    if (y[4])
      r = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
    else
      r = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) ||
          (y[3:0] == 4'd8);
    return r;
  endfunction

  function automatic logic [7:0] max_day(
    input logic [7:0] m,
    input logic [7:0] y
  );
    logic [7:0] r;
    case (m)
      8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
      8'h02:   r = is_leap(y) ? 8'h29 : 8'h28;
      default: r = 8'h31;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] x);
    logic [7:0] r;
    if (x[3:0] == 4'd9)
      r = {x[7:4] + 4'd1, 4'd0};
    else
      r = {x[7:4], x[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] x);
    logic [7:0] r;
    if (x[3:0] == 4'd0)
      r = {x[7:4] - 4'd1, 4'd9};
    else
      r = {x[7:4], x[3:0] - 4'd1};
    return r;
  endfunction

  // sync -> debounce -> 1->0 edge pulse, per key
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      press <= '0;
      for (int i = 0; i < 4; i++)
        dcnt[i] <= '0;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
          dcnt[i]  <= '0;
          deb[i]   <= sync2[i];
          press[i] <= ~sync2[i];
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign act[2] = press[2];
  assign act[3] = press[3] & ~press[2];
  assign act[0] = press[0] & ~|press[3:2] &
                  (mode_q != RUN);
  assign act[1] = press[1] & ~|press[3:2] &
                  ~press[0] & (mode_q != RUN);

  always_comb begin
    mode_d = mode_q;
    day_d  = day_q;
    mon_d  = mon_q;
    yr_d   = yr_q;
    mx_cur = max_day(mon_q, yr_q);
    if (mode_q == RUN && day_tick) begin
      if (day_q != mx_cur) begin
        day_d = bcd_inc(day_q);
      end else begin
        day_d = 8'h01;
        if (mon_q == 8'h12) begin
          mon_d = 8'h01;
          yr_d  = (yr_q == 8'h99) ? 8'h00 : bcd_inc(yr_q);
        end else begin
          mon_d = bcd_inc(mon_q);
        end
      end
    end
    unique case (1'b1)
      act[2]: mode_d = RUN;
      act[3]: mode_d = mode_e'(2'(mode_q) + 2'd1);
      act[0]: begin
        unique case (mode_q)
          SET_DAY:
            day_d = (day_q == mx_cur) ? 8'h01 : bcd_inc(day_q);
          SET_MONTH:
            mon_d = (mon_q == 8'h12) ? 8'h01 : bcd_inc(mon_q);
          SET_YEAR:
            yr_d = (yr_q == 8'h99) ? 8'h00 : bcd_inc(yr_q);
          default: ;
        endcase
      end
      act[1]: begin
        unique case (mode_q)
          SET_DAY:
            day_d = (day_q == 8'h01) ? mx_cur : bcd_dec(day_q);
          SET_MONTH:
            mon_d = (mon_q == 8'h01) ? 8'h12 : bcd_dec(mon_q);
          SET_YEAR:
            yr_d = (yr_q == 8'h00) ? 8'h99 : bcd_dec(yr_q);
          default: ;
        endcase
      end
      default: ;
    endcase
    // keep day legal when month/year shrinks the month
    mx_new = max_day(mon_d, yr_d);
    if (day_d > mx_new)
      day_d = mx_new;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      mode_q <= RUN;
      day_q  <= 8'h01;
      mon_q  <= 8'h01;
      yr_q   <= 8'h00;
    end else begin
      mode_q <= mode_d;
      day_q  <= day_d;
      mon_q  <= mon_d;
      yr_q   <= yr_d;
    end
  end

  // restart blink on any mode change so the new field shows at once
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (mode_d != mode_q || mode_q == RUN) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  always_comb begin
    blank = 3'b000;
    if (phase) begin
      unique case (mode_q)
        SET_DAY:   blank = 3'b001;
        SET_MONTH: blank = 3'b010;
        SET_YEAR:  blank = 3'b100;
        default:   blank = 3'b000;
      endcase
    end
  end

  assign day_bcd   = day_q;
  assign month_bcd = mon_q;
  assign year_bcd  = {8'h20, yr_q};
  assign mode      = 2'(mode_q);

endmodule

// File: tb/tb_date_set_ctrl.sv
// Bench for date_set_ctrl: table of key/tick vectors through a scoreboard
// queue, plus bounce, simultaneous-key, blink and mid-run reset sequences.

module tb_date_set_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  KEY;
  logic        day_tick;
  logic [7:0]  day_bcd;
  logic [7:0]  month_bcd;
  logic [15:0] year_bcd;
  logic [1:0]  mode;
  logic [2:0]  blank;

  always #5 clk = ~clk;

  date_set_ctrl #(
    .DEB_CYCLES(DEB),
    .BLINK_DIV (BLK)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .KEY      (KEY),
    .day_tick (day_tick),
    .day_bcd  (day_bcd),
    .month_bcd(month_bcd),
    .year_bcd (year_bcd),
    .mode     (mode),
    .blank    (blank)
  );

  typedef struct packed {
    logic [7:0]  d;
    logic [7:0]  m;
    logic [15:0] y;
    logic [1:0]  md;
  } date_t;

  typedef struct {
    int         op;
    logic [3:0] k;
    date_t      e;
  } vec_t;

  vec_t  tbl[$];
  date_t exp_q[$];
  date_t cur;
  int    n_vec = 0;
  int    n_err = 0;

  function automatic date_t dt(
    input logic [7:0]  d,
    input logic [7:0]  m,
    input logic [15:0] y,
    input logic [1:0]  md
  );
    date_t r;
    r = {d, m, y, md};
    return r;
  endfunction

  function automatic void add(
    input int          op,
    input logic [3:0]  k,
    input logic [7:0]  d,
    input logic [7:0]  m,
    input logic [15:0] y,
    input logic [1:0]  md
  );
    vec_t v;
    v.op = op;
    v.k  = k;
    v.e  = dt(d, m, y, md);
    tbl.push_back(v);
  endfunction

  task automatic check(
    input string      nm,
    input date_t      e,
    input logic       chkb,
    input logic [2:0] eb
  );
    n_vec++;
    if ({day_bcd, month_bcd, year_bcd, mode} !== e ||
        (chkb && blank !== eb)) begin
      n_err++;
      $display("FAIL %s: got %h.%h.%h mode %0d blank %b, want %h.%h.%h mode %0d blank %b",
               nm, day_bcd, month_bcd, year_bcd, mode, blank,
               e.d, e.m, e.y, e.md, eb);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    date_t e;
    logic  cb;
    exp_q.push_back(v.e);
    if (v.op == 0) begin
      @(negedge clk);
      day_tick = 1'b1;
      @(posedge clk);
      #1;
      day_tick = 1'b0;
    end else begin
      @(negedge clk);
      KEY = ~v.k;
      repeat (DEB + 2) @(posedge clk);
      #1;
      check({nm, "_early"}, cur, 1'b0, 3'b000);
      @(posedge clk);
      #1;
    end
    e  = exp_q.pop_front();
    cb = (e.md == 2'd0) || (e.md != cur.md);
    check(nm, e, cb, 3'b000);
    cur = e;
    if (v.op != 0) begin
      @(negedge clk);
      KEY = 4'hF;
      repeat (DEB + 6) @(posedge clk);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: bench did not finish, want finish");
    $fatal(1);
  end

  initial begin
    // T1: ticks from reset
    add(0, 4'h0, 8'h02, 8'h01, 16'h2000, 2'd0);
    add(0, 4'h0, 8'h03, 8'h01, 16'h2000, 2'd0);
    add(0, 4'h0, 8'h04, 8'h01, 16'h2000, 2'd0);
    // T2: 28.02.2001 -> 01.03.2001
    add(1, 4'h8, 8'h04, 8'h01, 16'h2000, 2'd1);
    add(1, 4'h2, 8'h03, 8'h01, 16'h2000, 2'd1);
    add(1, 4'h2, 8'h02, 8'h01, 16'h2000, 2'd1);
    add(1, 4'h2, 8'h01, 8'h01, 16'h2000, 2'd1);
    add(1, 4'h2, 8'h31, 8'h01, 16'h2000, 2'd1);
    add(1, 4'h2, 8'h30, 8'h01, 16'h2000, 2'd1);
    add(1, 4'h2, 8'h29, 8'h01, 16'h2000, 2'd1);
    add(1, 4'h2, 8'h28, 8'h01, 16'h2000, 2'd1);
    add(1, 4'h8, 8'h28, 8'h01, 16'h2000, 2'd2);
    add(1, 4'h1, 8'h28, 8'h02, 16'h2000, 2'd2);
    add(1, 4'h8, 8'h28, 8'h02, 16'h2000, 2'd3);
    add(1, 4'h1, 8'h28, 8'h02, 16'h2001, 2'd3);
    add(1, 4'h8, 8'h28, 8'h02, 16'h2001, 2'd0);
    add(0, 4'h0, 8'h01, 8'h03, 16'h2001, 2'd0);
    // 28.02.2004 -> 29.02 -> 01.03
    add(1, 4'h8, 8'h01, 8'h03, 16'h2001, 2'd1);
    add(1, 4'h2, 8'h31, 8'h03, 16'h2001, 2'd1);
    add(1, 4'h2, 8'h30, 8'h03, 16'h2001, 2'd1);
    add(1, 4'h2, 8'h29, 8'h03, 16'h2001, 2'd1);
    add(1, 4'h2, 8'h28, 8'h03, 16'h2001, 2'd1);
    add(1, 4'h8, 8'h28, 8'h03, 16'h2001, 2'd2);
    add(1, 4'h2, 8'h28, 8'h02, 16'h2001, 2'd2);
    add(1, 4'h8, 8'h28, 8'h02, 16'h2001, 2'd3);
    add(1, 4'h1, 8'h28, 8'h02, 16'h2002, 2'd3);
    add(1, 4'h1, 8'h28, 8'h02, 16'h2003, 2'd3);
    add(1, 4'h1, 8'h28, 8'h02, 16'h2004, 2'd3);
    add(1, 4'h4, 8'h28, 8'h02, 16'h2004, 2'd0);
    add(0, 4'h0, 8'h29, 8'h02, 16'h2004, 2'd0);
    add(0, 4'h0, 8'h01, 8'h03, 16'h2004, 2'd0);
    // T3: 31.12.2099 -> 01.01.2000
    add(1, 4'h8, 8'h01, 8'h03, 16'h2004, 2'd1);
    add(1, 4'h8, 8'h01, 8'h03, 16'h2004, 2'd2);
    add(1, 4'h2, 8'h01, 8'h02, 16'h2004, 2'd2);
    add(1, 4'h2, 8'h01, 8'h01, 16'h2004, 2'd2);
    add(1, 4'h2, 8'h01, 8'h12, 16'h2004, 2'd2);
    add(1, 4'h8, 8'h01, 8'h12, 16'h2004, 2'd3);
    add(1, 4'h2, 8'h01, 8'h12, 16'h2003, 2'd3);
    add(1, 4'h2, 8'h01, 8'h12, 16'h2002, 2'd3);
    add(1, 4'h2, 8'h01, 8'h12, 16'h2001, 2'd3);
    add(1, 4'h2, 8'h01, 8'h12, 16'h2000, 2'd3);
    add(1, 4'h2, 8'h01, 8'h12, 16'h2099, 2'd3);
    add(1, 4'h8, 8'h01, 8'h12, 16'h2099, 2'd0);
    add(1, 4'h8, 8'h01, 8'h12, 16'h2099, 2'd1);
    add(1, 4'h2, 8'h31, 8'h12, 16'h2099, 2'd1);
    add(1, 4'h4, 8'h31, 8'h12, 16'h2099, 2'd0);
    add(0, 4'h0, 8'h01, 8'h01, 16'h2000, 2'd0);
    // T4: clamp on month and on year change, day wraps
    add(1, 4'h8, 8'h01, 8'h01, 16'h2000, 2'd1);
    add(1, 4'h2, 8'h31, 8'h01, 16'h2000, 2'd1);
    add(1, 4'h8, 8'h31, 8'h01, 16'h2000, 2'd2);
    add(1, 4'h8, 8'h31, 8'h01, 16'h2000, 2'd3);
    add(1, 4'h1, 8'h31, 8'h01, 16'h2001, 2'd3);
    add(1, 4'h8, 8'h31, 8'h01, 16'h2001, 2'd0);
    add(1, 4'h8, 8'h31, 8'h01, 16'h2001, 2'd1);
    add(1, 4'h8, 8'h31, 8'h01, 16'h2001, 2'd2);
    add(1, 4'h1, 8'h28, 8'h02, 16'h2001, 2'd2);
    add(1, 4'h8, 8'h28, 8'h02, 16'h2001, 2'd3);
    add(1, 4'h2, 8'h28, 8'h02, 16'h2000, 2'd3);
    add(1, 4'h8, 8'h28, 8'h02, 16'h2000, 2'd0);
    add(1, 4'h8, 8'h28, 8'h02, 16'h2000, 2'd1);
    add(1, 4'h1, 8'h29, 8'h02, 16'h2000, 2'd1);
    add(1, 4'h1, 8'h01, 8'h02, 16'h2000, 2'd1);
    add(1, 4'h2, 8'h29, 8'h02, 16'h2000, 2'd1);
    add(1, 4'h8, 8'h29, 8'h02, 16'h2000, 2'd2);
    add(1, 4'h8, 8'h29, 8'h02, 16'h2000, 2'd3);
    add(1, 4'h2, 8'h28, 8'h02, 16'h2099, 2'd3);
    add(1, 4'h8, 8'h28, 8'h02, 16'h2099, 2'd0);
    // KEY[0] ignored in RUN
    add(1, 4'h1, 8'h28, 8'h02, 16'h2099, 2'd0);
    add(1, 4'h8, 8'h28, 8'h02, 16'h2099, 2'd1);

    reset    = 1'b1;
    KEY      = 4'hF;
    day_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cur = dt(8'h01, 8'h01, 16'h2000, 2'd0);
    check("reset", cur, 1'b1, 3'b000);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // T5: bouncing KEY[0] in SET_DAY at 28.02.2099 -> one wrap to 01
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      KEY = {3'b111, i[0]};
      @(negedge clk);
    end
    KEY = 4'hE;
    repeat (12) @(negedge clk);
    KEY = 4'hF;
    repeat (12) @(negedge clk);
    cur = dt(8'h01, 8'h02, 16'h2099, 2'd1);
    check("bounce", cur, 1'b0, 3'b000);

    begin
      vec_t v;
      v.op = 1;
      v.k  = 4'h5;
      v.e  = dt(8'h01, 8'h02, 16'h2099, 2'd0);
      apply(v, "k0_k2");
      v.k  = 4'h9;
      v.e  = dt(8'h01, 8'h02, 16'h2099, 2'd1);
      apply(v, "k0_k3");
    end

    // T6: blink in SET_MONTH, tick dropped, reset mid-blink
    @(negedge clk);
    KEY = 4'h7;
    repeat (DEB + 3) @(posedge clk);
    #1;
    KEY = 4'hF;
    cur = dt(8'h01, 8'h02, 16'h2099, 2'd2);
    for (int j = 0; j < 24; j++) begin
      check($sformatf("blink%0d", j), cur, 1'b1,
            ((j / BLK) % 2 == 1) ? 3'b010 : 3'b000);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    day_tick = 1'b1;
    @(posedge clk);
    #1;
    day_tick = 1'b0;
    check("tick_in_set", cur, 1'b1, 3'b010);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cur = dt(8'h01, 8'h01, 16'h2000, 2'd0);
    check("mid_reset", cur, 1'b1, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("after_reset", cur, 1'b1, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
